minilcd_rx: RTL



---
 rtl/minilcd_rx.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/minilcd_rx.sv
// Receive side of the MiniLCD 8-bit parallel write bus: decodes commands and
// parameters and turns RGB565 pixel pairs into 4-bit frame-buffer writes.
module minilcd_rx #(
  parameter int COL_OFS = 2,
  parameter int ROW_OFS = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LCD_CS0,
  input  logic        LCD_CD,
  input  logic        LCD_WR,
  input  logic        LCD_RSTB,
  input  logic [7:0]  LCD_D,
  output logic        FB_WE,
  output logic [13:0] FB_ADDR,
  output logic [3:0]  FB_DATA,
  output logic        DISP_ON,
  output logic        SLEEP_OUT,
  output logic [7:0]  MADCTL,
  output logic [7:0]  COLMOD,
  output logic        ERR
);

  // state | meaning
  // IDLE  | waiting for a command; parameter bytes flag ERR unless skip_q
  // PARAM | collecting parameter bytes for cmd_q
  // PIXEL | collecting RGB565 byte pairs for memory write
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PARAM = 2'd1;
  localparam logic [1:0] ST_PIXEL = 2'd2;

  localparam logic [7:0] COL_OFS8 = 8'(COL_OFS);
  localparam logic [7:0] ROW_OFS8 = 8'(ROW_OFS);

  logic       s_cs_q, s_cd_q, s_wr_q, s_wr_d_q, s_rstb_q;
  logic [7:0] s_d_q;
  logic       bv_q, bcd_q;
  logic [7:0] bd_q;
  logic       bv_d;

  logic [1:0] state_q, state_d, cnt_q, cnt_d;
  logic       phase_q, phase_d, skip_q, skip_d;
  logic [7:0] cmd_q, cmd_d, b0_q, b0_d;
  logic [7:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [7:0] madctl_q, madctl_d, colmod_q, colmod_d;
  logic       disp_q, disp_d, sleep_q, sleep_d, err_q, err_d;
  logic       fb_we_q, fb_we_d;
  logic [13:0] fb_addr_q, fb_addr_d;
  logic [3:0]  fb_data_q, fb_data_d;
  logic       sw_rst;
  logic [7:0] col, row;

  assign bv_d = s_wr_q & ~s_wr_d_q & ~s_cs_q & s_rstb_q;
  assign col  = x_q - COL_OFS8;
  assign row  = y_q - ROW_OFS8;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    skip_d    = skip_q;
    cmd_d     = cmd_q;
    b0_d      = b0_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    x_d       = x_q;
    y_d       = y_q;
    madctl_d  = madctl_q;
    colmod_d  = colmod_q;
    disp_d    = disp_q;
    sleep_d   = sleep_q;
    err_d     = err_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    sw_rst    = 1'b0;

    if (bv_q) begin
      if (!bcd_q) begin
        // Any command byte aborts the current stream and drops a half pixel.
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
        phase_d = 1'b0;
        skip_d  = 1'b0;
        cmd_d   = bd_q;
        case (bd_q)
          8'h01: sw_rst = 1'b1;
          8'h11: sleep_d = 1'b1;
          8'h28: disp_d = 1'b0;
          8'h29: disp_d = 1'b1;
          8'h2A, 8'h2B, 8'h36, 8'h3A: state_d = ST_PARAM;
          8'h2C: begin
            state_d = ST_PIXEL;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: skip_d = 1'b1;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: if (!skip_q) err_d = 1'b1;
          ST_PARAM: begin
            cnt_d = cnt_q + 2'd1;
            case (cmd_q)
              8'h2A, 8'h2B: begin
                case (cnt_q)
                  2'd0, 2'd2: if (bd_q != 8'h00) err_d = 1'b1;
                  2'd1: if (cmd_q == 8'h2A) xs_d = bd_q; else ys_d = bd_q;
                  default: begin
                    state_d = ST_IDLE;
                    if (cmd_q == 8'h2A) begin
                      xe_d = bd_q;
                      if (xs_q > bd_q) err_d = 1'b1;
                    end else begin
                      ye_d = bd_q;
                      if (ys_q > bd_q) err_d = 1'b1;
                    end
                  end
                endcase
              end
              8'h36: begin
                madctl_d = bd_q;
                state_d  = ST_IDLE;
              end
              8'h3A: begin
                colmod_d = bd_q;
                state_d  = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
          ST_PIXEL: begin
            if (!phase_q) begin
              b0_d    = bd_q;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (!col[7] && !row[7]) begin
                fb_we_d   = 1'b1;
                fb_addr_d = {row[6:0], col[6:0]};
                fb_data_d = {1'b0, b0_q[6], b0_q[2], bd_q[4]};
              end
              if (x_q == xe_q) begin
                x_d = xs_q;
                y_d = (y_q == ye_q) ? ys_q : y_q + 8'd1;
              end else begin
                x_d = x_q + 8'd1;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Software and pin reset restore everything but the sticky error flag.
    if (sw_rst || !s_rstb_q) begin
      state_d   = ST_IDLE;
      cnt_d     = 2'd0;
      phase_d   = 1'b0;
      skip_d    = 1'b0;
      cmd_d     = 8'h00;
      b0_d      = 8'h00;
      xs_d      = 8'd0;
      xe_d      = 8'd127;
      ys_d      = 8'd0;
      ye_d      = 8'd127;
      x_d       = 8'd0;
      y_d       = 8'd0;
      madctl_d  = 8'h00;
      colmod_d  = 8'h00;
      disp_d    = 1'b0;
      sleep_d   = 1'b0;
      fb_we_d   = 1'b0;
      fb_addr_d = 14'd0;
      fb_data_d = 4'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_cs_q    <= 1'b1;
      s_cd_q    <= 1'b0;
      s_wr_q    <= 1'b1;
      s_wr_d_q  <= 1'b1;
      s_rstb_q  <= 1'b1;
      s_d_q     <= 8'h00;
      bv_q      <= 1'b0;
      bcd_q     <= 1'b0;
      bd_q      <= 8'h00;
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      phase_q   <= 1'b0;
      skip_q    <= 1'b0;
      cmd_q     <= 8'h00;
      b0_q      <= 8'h00;
      xs_q      <= 8'd0;
      xe_q      <= 8'd127;
      ys_q      <= 8'd0;
      ye_q      <= 8'd127;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      madctl_q  <= 8'h00;
      colmod_q  <= 8'h00;
      disp_q    <= 1'b0;
      sleep_q   <= 1'b0;
      err_q     <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= 14'd0;
      fb_data_q <= 4'd0;
    end else begin
      s_cs_q    <= LCD_CS0;
      s_cd_q    <= LCD_CD;
      s_wr_q    <= LCD_WR;
      s_wr_d_q  <= s_wr_q;
      s_rstb_q  <= LCD_RSTB;
      s_d_q     <= LCD_D;
      bv_q      <= bv_d;
      bcd_q     <= s_cd_q;
      bd_q      <= s_d_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      skip_q    <= skip_d;
      cmd_q     <= cmd_d;
      b0_q      <= b0_d;
      xs_q      <= xs_d;
      xe_q      <= xe_d;
      ys_q      <= ys_d;
      ye_q      <= ye_d;
      x_q       <= x_d;
      y_q       <= y_d;
      madctl_q  <= madctl_d;
      colmod_q  <= colmod_d;
      disp_q    <= disp_d;
      sleep_q   <= sleep_d;
      err_q     <= err_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign FB_WE     = fb_we_q;
  assign FB_ADDR   = fb_addr_q;
  assign FB_DATA   = fb_data_q;
  assign DISP_ON   = disp_q;
  assign SLEEP_OUT = sleep_q;
  assign MADCTL    = madctl_q;
  assign COLMOD    = colmod_q;
  assign ERR       = err_q;

endmodule
